// File: rtl/uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : uart_rx_core
// 8N1 UART receiver: oversampled deframing with a valid/read output register.
// Rev    : 1.0
// ============================================================================
module uart_rx_core #(
  parameter int CLK_FREQ   = 48_000_000,
  parameter int BAUD_RATE  = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clkIN,
  input  logic       resetIN,
  input  logic       rxIN,
  input  logic       readIN,
  output logic [7:0] dataOUT,
  output logic       dataValidOUT,
  output logic       frameErrOUT,
  output logic       overrunOUT,
  output logic       busyOUT
);

  localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SMP_W = $clog2(OVERSAMPLE);

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(DIV - 1);
  localparam logic [SMP_W-1:0] SMP_LAST = SMP_W'(OVERSAMPLE - 1);
  localparam logic [SMP_W-1:0] SMP_MID  = SMP_W'(OVERSAMPLE / 2 - 1);

  generate
    if (DIV < 1) begin : g_div_invalid
      $error("uart_rx_core: CLK_FREQ/(BAUD_RATE*OVERSAMPLE) must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_rx_meta;
  logic             r_rx_s;
  logic [DIV_W-1:0] r_div_cnt;
  logic [SMP_W-1:0] r_smp_cnt;
  logic [2:0]       r_bit_cnt;
  logic [7:0]       r_shift;
  logic             r_load_pend;
  logic             w_tick;

  // Synchronizer flops idle high so reset never looks like a start edge.
  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rxIN;
      r_rx_s    <= r_rx_meta;
    end
  end

  assign w_tick = (r_div_cnt == DIV_LAST);

  always_ff @(posedge clkIN) begin
    if (resetIN) begin
      r_state      <= S_IDLE;
      r_div_cnt    <= '0;
      r_smp_cnt    <= '0;
      r_bit_cnt    <= '0;
      r_shift      <= '0;
      r_load_pend  <= 1'b0;
      dataOUT      <= '0;
      dataValidOUT <= 1'b0;
      frameErrOUT  <= 1'b0;
      overrunOUT   <= 1'b0;
      busyOUT      <= 1'b0;
    end else begin
      r_load_pend <= 1'b0;
      frameErrOUT <= 1'b0;

      // Divider is held at zero in IDLE so sampling phase locks to the start edge.
      if (r_state == S_IDLE || w_tick) begin
        r_div_cnt <= '0;
      end else begin
        r_div_cnt <= r_div_cnt + DIV_W'(1);
      end

      case (r_state)
        S_IDLE: begin
          if (!r_rx_s) begin
            r_state   <= S_START;
            r_smp_cnt <= '0;
            busyOUT   <= 1'b1;
          end
        end
        S_START: begin
          if (w_tick) begin
            if (r_smp_cnt == SMP_MID) begin
              r_smp_cnt <= '0;
              r_bit_cnt <= '0;
              if (r_rx_s) begin
                r_state <= S_IDLE;
                busyOUT <= 1'b0;
              end else begin
                r_state <= S_DATA;
              end
            end else begin
              r_smp_cnt <= r_smp_cnt + SMP_W'(1);
            end
          end
        end
        S_DATA: begin
          if (w_tick) begin
            if (r_smp_cnt == SMP_LAST) begin
              r_smp_cnt <= '0;
              r_shift   <= {r_rx_s, r_shift[7:1]};
              if (r_bit_cnt == 3'd7) begin
                r_state <= S_STOP;
              end else begin
                r_bit_cnt <= r_bit_cnt + 3'd1;
              end
            end else begin
              r_smp_cnt <= r_smp_cnt + SMP_W'(1);
            end
          end
        end
        S_STOP: begin
          if (w_tick) begin
            if (r_smp_cnt == SMP_LAST) begin
              r_smp_cnt <= '0;
              if (r_rx_s) begin
                r_state     <= S_IDLE;
                busyOUT     <= 1'b0;
                r_load_pend <= 1'b1;
              end else begin
                r_state     <= S_BREAK;
                frameErrOUT <= 1'b1;
              end
            end else begin
              r_smp_cnt <= r_smp_cnt + SMP_W'(1);
            end
          end
        end
        S_BREAK: begin
          if (r_rx_s) begin
            r_state <= S_IDLE;
            busyOUT <= 1'b0;
          end
        end
        default: begin
          r_state <= S_IDLE;
          busyOUT <= 1'b0;
        end
      endcase

      // A pending load wins over a same-cycle read; the read still clears overrun.
      if (r_load_pend && (!dataValidOUT || readIN)) begin
        dataOUT      <= r_shift;
        dataValidOUT <= 1'b1;
        if (readIN) begin
          overrunOUT <= 1'b0;
        end
      end else if (r_load_pend) begin
        overrunOUT <= 1'b1;
      end else if (readIN) begin
        dataValidOUT <= 1'b0;
        overrunOUT   <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_core.sv
`default_nettype none
// ============================================================================
// Module : tb_uart_rx_core
// Directed and random 8N1 frames against a frame-level receiver model.
// Rev    : 1.0
// ============================================================================
module tb_uart_rx_core;

  localparam int CLK_FREQ   = 160;
  localparam int BAUD_RATE  = 1;
  localparam int OVERSAMPLE = 16;
  localparam int BIT_CLKS   = CLK_FREQ / BAUD_RATE;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx  = 1'b1;
  logic       rd  = 1'b0;
  logic [7:0] data;
  logic       valid;
  logic       ferr;
  logic       ovr;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int fe_cycles = 0;
  int fe_with_rise = 0;
  logic prev_valid = 1'b0;

  logic [7:0] m_data;
  logic       m_valid;
  logic       m_ovr;

  uart_rx_core #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD_RATE (BAUD_RATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) dut (
    .clkIN       (clk),
    .resetIN     (rst),
    .rxIN        (rx),
    .readIN      (rd),
    .dataOUT     (data),
    .dataValidOUT(valid),
    .frameErrOUT (ferr),
    .overrunOUT  (ovr),
    .busyOUT     (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (ferr === 1'b1) fe_cycles++;
    if (ferr === 1'b1 && valid === 1'b1 && prev_valid === 1'b0) fe_with_rise++;
    prev_valid = valid;
  end

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_data = 8'h00; m_valid = 1'b0; m_ovr = 1'b0;
  endtask

  task automatic model_rx(input logic [7:0] b);
    if (!m_valid) begin
      m_data  = b;
      m_valid = 1'b1;
    end else begin
      m_ovr = 1'b1;
    end
  endtask

  task automatic check_model(input string tag);
    check({tag, ".data"},    data,  m_data);
    check({tag, ".valid"},   valid, m_valid);
    check({tag, ".overrun"}, ovr,   m_ovr);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_read();
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    m_valid = 1'b0;
    m_ovr   = 1'b0;
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    idle(BIT_CLKS);
  endtask

  // Optionally reads the previous byte early in this frame's start bit.
  task automatic send_frame(input logic [7:0] b, input logic stop, input logic read_in_start,
                            input string tag);
    rx = 1'b0;
    if (read_in_start) begin
      idle(20);
      check_model(tag);
      pulse_read();
      idle(BIT_CLKS - 21);
    end else begin
      idle(BIT_CLKS);
    end
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  initial begin
    int fe0;
    int w;
    logic [7:0] rb;

    model_reset();
    @(negedge clk);
    idle(5);
    rst = 1'b0;
    idle(2);
    check("rst.data", data, 8'h00);
    check("rst.valid", valid, 1'b0);
    check("rst.ferr", ferr, 1'b0);
    check("rst.overrun", ovr, 1'b0);
    check("rst.busy", busy, 1'b0);

    // Single frame, then a read
    idle(2 * BIT_CLKS);
    send_frame(8'h55, 1'b1, 1'b0, "");
    model_rx(8'h55);
    idle(BIT_CLKS);
    check_model("f55");
    check("f55.busy", busy, 1'b0);
    pulse_read();
    check("f55.rd_valid", valid, 1'b0);

    // Back-to-back frames, read during the second frame's start bit
    fe0 = fe_cycles;
    send_frame(8'hA3, 1'b1, 1'b0, "");
    model_rx(8'hA3);
    send_frame(8'h0F, 1'b1, 1'b1, "b2b_a3");
    model_rx(8'h0F);
    idle(BIT_CLKS);
    check_model("b2b_0f");
    check("b2b.ferr_cnt", fe_cycles - fe0, 0);
    pulse_read();

    // Start glitch shorter than half a bit
    rx = 1'b0;
    idle(20);
    check("glitch.busy_hi", busy, 1'b1);
    idle(20);
    rx = 1'b1;
    idle(BIT_CLKS);
    check("glitch.busy_lo", busy, 1'b0);
    check_model("glitch");
    check("glitch.ferr_cnt", fe_cycles - fe0, 0);

    // Framing error followed by a break, then a good frame
    fe0 = fe_cycles;
    send_frame(8'h3C, 1'b0, 1'b0, "");
    idle(2 * BIT_CLKS);
    check("ferr.pulse_cycles", fe_cycles - fe0, 1);
    check("ferr.busy_break", busy, 1'b1);
    check_model("ferr");
    rx = 1'b1;
    idle(BIT_CLKS);
    check("ferr.busy_lo", busy, 1'b0);
    send_frame(8'h81, 1'b1, 1'b0, "");
    model_rx(8'h81);
    idle(BIT_CLKS);
    check_model("f81");
    pulse_read();

    // Overrun with no read
    send_frame(8'h11, 1'b1, 1'b0, "");
    model_rx(8'h11);
    idle(BIT_CLKS);
    send_frame(8'h22, 1'b1, 1'b0, "");
    model_rx(8'h22);
    idle(BIT_CLKS);
    check_model("ovr");
    pulse_read();
    check_model("ovr_rd");

    // Read landing exactly in the load cycle of the second byte
    send_frame(8'h11, 1'b1, 1'b0, "");
    model_rx(8'h11);
    idle(BIT_CLKS);
    rb = 8'h22;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(rb[i]);
    rx = 1'b1;
    w = 0;
    while (busy !== 1'b0 && w < BIT_CLKS) begin
      @(negedge clk);
      w++;
    end
    check("ldrd.busy_fell", (w < BIT_CLKS), 1'b1);
    rd = 1'b1;
    @(negedge clk);
    rd = 1'b0;
    w++;
    m_data = 8'h22; m_valid = 1'b1; m_ovr = 1'b0;
    if (w < BIT_CLKS) idle(BIT_CLKS - w);
    idle(BIT_CLKS);
    check_model("ldrd");

    // Reset during data bit 4 of 0xFF with an unread byte pending
    send_bit(1'b0);
    for (int i = 0; i < 4; i++) send_bit(1'b1);
    rx = 1'b1;
    idle(BIT_CLKS / 2);
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    model_reset();
    idle(1);
    check_model("midrst");
    check("midrst.busy", busy, 1'b0);
    check("midrst.ferr", ferr, 1'b0);
    idle(5 * BIT_CLKS);
    send_frame(8'h5A, 1'b1, 1'b0, "");
    model_rx(8'h5A);
    idle(BIT_CLKS);
    check_model("f5a");

    // Random frames with random reads in the idle gaps
    for (int n = 0; n < 6; n++) begin
      rb = 8'($urandom_range(0, 255));
      send_frame(rb, 1'b1, 1'b0, "");
      model_rx(rb);
      idle(BIT_CLKS / 2 + $urandom_range(0, BIT_CLKS));
      check_model($sformatf("rnd%0d", n));
      check($sformatf("rnd%0d.busy", n), busy, 1'b0);
      if ($urandom_range(0, 1) == 1) pulse_read();
    end

    check("ferr_vs_valid_rise", fe_with_rise, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
